// File: rtl/operand_fetch.sv
// Operand fetch: turns CONTROLLER read strobes into synchronous-SRAM reads on the
// IFM, weight and bias buffers, and returns each word one cycle later with a valid flag.
// IFM reads walk 3x3 windows (conv/pool) or a linear vector (fully).
module operand_fetch #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned IFM_W  = 8,
  parameter int unsigned STRIDE = 1,
  parameter int unsigned NWIN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] wgt_base,
  input  logic [ADDR_W-1:0] bias_base,
  input  logic [NWIN_W-1:0] num_windows,
  input  logic              ifm_read,
  input  logic              wgt_read,
  input  logic              bias_read,
  output logic              ifm_mem_en,
  output logic [ADDR_W-1:0] ifm_mem_addr,
  input  logic [DATA_W-1:0] ifm_mem_rdata,
  output logic              wgt_mem_en,
  output logic [ADDR_W-1:0] wgt_mem_addr,
  input  logic [DATA_W-1:0] wgt_mem_rdata,
  output logic              bias_mem_en,
  output logic [ADDR_W-1:0] bias_mem_addr,
  input  logic [DATA_W-1:0] bias_mem_rdata,
  output logic [DATA_W-1:0] ifm_data,
  output logic              ifm_valid,
  output logic [DATA_W-1:0] wgt_data,
  output logic              wgt_valid,
  output logic [DATA_W-1:0] bias_data,
  output logic              bias_valid,
  output logic [3:0]        tap_idx,
  output logic              window_done,
  output logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [0:0] {StIdle, StArmed} state_e;

  localparam logic [3:0] ModeConv  = 4'b0001;
  localparam logic [3:0] ModePool  = 4'b0010;
  localparam logic [3:0] ModeFully = 4'b0011;

  localparam logic [ADDR_W-1:0] RowStride  = ADDR_W'(IFM_W);
  localparam logic [ADDR_W-1:0] ColStep    = ADDR_W'(STRIDE);
  // Largest window origin column whose 3 columns still fit in the row.
  localparam logic [ADDR_W-1:0] LastOrigin = ADDR_W'(IFM_W - 3);

  state_e            state_q, state_d;
  logic [3:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] ifm_base_q, ifm_base_d;
  logic [ADDR_W-1:0] wgt_base_q, wgt_base_d;
  logic [ADDR_W-1:0] bias_base_q, bias_base_d;
  logic [NWIN_W-1:0] nwin_q, nwin_d;
  logic [3:0]        tap_q, tap_d;
  logic [ADDR_W-1:0] ocol_q, ocol_d;
  logic [ADDR_W-1:0] orow_q, orow_d;
  logic [ADDR_W-1:0] lin_q, lin_d;
  logic [NWIN_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] wgt_cnt_q, wgt_cnt_d;
  logic [ADDR_W-1:0] bias_cnt_q, bias_cnt_d;
  logic              err_q, err_d;

  logic              ifm_valid_q, wgt_valid_q, bias_valid_q;
  logic [3:0]        tap_out_q;
  logic              wdone_q, done_q;

  logic              armed, gate, start_ok, mode_legal, is_fully;
  logic              ifm_issue, wgt_issue, bias_issue;
  logic              last_tap, last_win;
  logic [1:0]        tap_row, tap_col;
  logic [ADDR_W-1:0] conv_addr, ocol_step;

  assign armed      = (state_q == StArmed);
  assign gate       = armed & ~start & ~rst;
  assign mode_legal = (mode == ModeConv) | (mode == ModePool) | (mode == ModeFully);
  assign start_ok   = start & mode_legal & (num_windows != '0);
  assign is_fully   = (mode_q == ModeFully);

  assign ifm_issue  = ifm_read & gate;
  assign wgt_issue  = wgt_read & gate;
  assign bias_issue = bias_read & gate;

  assign last_tap   = (tap_q == 4'd8);
  assign last_win   = (win_q == nwin_q - NWIN_W'(1));
  assign ocol_step  = ocol_q + ColStep;

  // Split tap index into window row/column offsets.
  always_comb begin
    tap_row = 2'd0;
    tap_col = 2'd0;
    case (tap_q)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      default:          tap_row = 2'd2;
    endcase
    case (tap_q)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      default:          tap_col = 2'd2;
    endcase
  end

  assign conv_addr = ifm_base_q + (orow_q + ADDR_W'(tap_row)) * RowStride
                   + ocol_q + ADDR_W'(tap_col);

  assign ifm_mem_en    = ifm_issue;
  assign wgt_mem_en    = wgt_issue;
  assign bias_mem_en   = bias_issue;
  assign ifm_mem_addr  = is_fully ? (ifm_base_q + lin_q) : conv_addr;
  assign wgt_mem_addr  = wgt_base_q + wgt_cnt_q;
  assign bias_mem_addr = bias_base_q + bias_cnt_q;

  // Next-state: FSM, job registers, address walkers and sticky error.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    ifm_base_d  = ifm_base_q;
    wgt_base_d  = wgt_base_q;
    bias_base_d = bias_base_q;
    nwin_d      = nwin_q;
    tap_d       = tap_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    lin_d       = lin_q;
    win_d       = win_q;
    wgt_cnt_d   = wgt_cnt_q;
    bias_cnt_d  = bias_cnt_q;
    err_d       = err_q;

    if (ifm_issue) begin
      lin_d = lin_q + ADDR_W'(1);
      if (last_tap) begin
        tap_d = 4'd0;
        win_d = win_q + NWIN_W'(1);
        if (!is_fully) begin
          if (ocol_step > LastOrigin) begin
            ocol_d = '0;
            orow_d = orow_q + ColStep;
          end else begin
            ocol_d = ocol_step;
          end
        end
        if (last_win) state_d = StIdle;
      end else begin
        tap_d = tap_q + 4'd1;
      end
    end
    if (wgt_issue)  wgt_cnt_d  = wgt_cnt_q + ADDR_W'(1);
    if (bias_issue) bias_cnt_d = bias_cnt_q + ADDR_W'(1);

    // A start always wins over the walkers; an illegal one abandons any job.
    if (start) begin
      if (start_ok) begin
        state_d     = StArmed;
        mode_d      = mode;
        ifm_base_d  = ifm_base;
        wgt_base_d  = wgt_base;
        bias_base_d = bias_base;
        nwin_d      = num_windows;
        tap_d       = '0;
        ocol_d      = '0;
        orow_d      = '0;
        lin_d       = '0;
        win_d       = '0;
        wgt_cnt_d   = '0;
        bias_cnt_d  = '0;
        err_d       = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end

    // Error set has priority over the clear from a legal start.
    if ((start & ~start_ok) |
        ((ifm_read | wgt_read | bias_read) & (~armed | start))) begin
      err_d = 1'b1;
    end
  end

  // State and walker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      ifm_base_q  <= '0;
      wgt_base_q  <= '0;
      bias_base_q <= '0;
      nwin_q      <= '0;
      tap_q       <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
      lin_q       <= '0;
      win_q       <= '0;
      wgt_cnt_q   <= '0;
      bias_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      ifm_base_q  <= ifm_base_d;
      wgt_base_q  <= wgt_base_d;
      bias_base_q <= bias_base_d;
      nwin_q      <= nwin_d;
      tap_q       <= tap_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
      lin_q       <= lin_d;
      win_q       <= win_d;
      wgt_cnt_q   <= wgt_cnt_d;
      bias_cnt_q  <= bias_cnt_d;
      err_q       <= err_d;
    end
  end

  // Return pipeline: tags travel one cycle alongside the SRAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifm_valid_q  <= 1'b0;
      wgt_valid_q  <= 1'b0;
      bias_valid_q <= 1'b0;
      tap_out_q    <= '0;
      wdone_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ifm_valid_q  <= ifm_issue;
      wgt_valid_q  <= wgt_issue;
      bias_valid_q <= bias_issue;
      tap_out_q    <= ifm_issue ? tap_q : 4'd0;
      wdone_q      <= ifm_issue & last_tap;
      done_q       <= ifm_issue & last_tap & last_win;
    end
  end

  assign ifm_valid   = ifm_valid_q;
  assign wgt_valid   = wgt_valid_q;
  assign bias_valid  = bias_valid_q;
  assign ifm_data    = ifm_valid_q  ? ifm_mem_rdata  : '0;
  assign wgt_data    = wgt_valid_q  ? wgt_mem_rdata  : '0;
  assign bias_data   = bias_valid_q ? bias_mem_rdata : '0;
  assign tap_idx     = tap_out_q;
  assign window_done = wdone_q;
  assign done        = done_q;
  assign busy        = armed;
  assign err         = err_q;

endmodule
